// File: rtl/ads1672_pkg.sv
// Shared types for the ADS1672 capture controller: FSM states and the
// default conversion word type.
package ads1672_pkg;

    localparam int unsigned ADS1672_DATA_WIDTH = 24;

    typedef logic [ADS1672_DATA_WIDTH-1:0] sample_t;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitDrdy,
        StShift,
        StDeliver
    } state_e;

endpackage

// File: rtl/ads1672_capture_ctrl_if.sv
// Valid/ready sample stream between the capture controller (master) and the
// downstream FIFO or DSP chain (slave).
interface ads1672_capture_ctrl_if
    import ads1672_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ADS1672_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] sample_data;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to
// ResetVal so an idle-high pin does not produce a false edge out of reset.
module sync_2ff
    import ads1672_pkg::*;
#(
    parameter int unsigned     Width    = 1,
    parameter logic [Width-1:0] ResetVal = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ads1672_capture_ctrl.sv
// ADS1672 link sequencer: start pulse, data-ready wait, clkx/fsx generation,
// MSB-first serial capture and valid/ready delivery with burst control.
module ads1672_capture_ctrl
    import ads1672_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = ADS1672_DATA_WIDTH,
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned START_CYCLES   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [CNT_W-1:0]             burst_len,
    output logic                         start,
    input  logic                         drdy_n,
    output logic                         clkx,
    output logic                         fsx,
    input  logic                         drr,
    ads1672_capture_ctrl_if.master       smp,
    output logic                         busy,
    output logic                         overrun,
    output logic                         timeout
);

    localparam int unsigned DivW = 9;
    localparam int unsigned BitW = 8;
    localparam int unsigned TmrW = 32;

    state_e                state_q, state_d;
    logic [TmrW-1:0]       tmr_q, tmr_d;
    logic [DivW-1:0]       div_q, div_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, burst_q, burst_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d, data_q, data_d;
    logic                  valid_q, valid_d, ovr_q, ovr_d, to_q, to_d;
    logic                  start_q, clkx_q, fsx_q;
    logic                  drdy_s, drr_s, drdy_prev_q, drdy_fall;

    sync_2ff #(.Width(1), .ResetVal(1'b1)) u_sync_drdy (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (drdy_n),
        .q_o   (drdy_s)
    );

    sync_2ff #(.Width(1), .ResetVal(1'b1)) u_sync_drr (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (drr),
        .q_o   (drr_s)
    );

    assign drdy_fall = drdy_prev_q & ~drdy_s;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        div_d   = div_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        to_d    = to_q;

        if (valid_q && smp.sample_ready) valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StStart;
                    burst_d = burst_len;
                    ovr_d   = 1'b0;
                    to_d    = 1'b0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end
            end
            StStart: begin
                if (tmr_q == TmrW'(START_CYCLES - 1)) begin
                    state_d = StWaitDrdy;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StWaitDrdy: begin
                if (drdy_fall) begin
                    state_d = StShift;
                    tmr_d   = '0;
                    div_d   = '0;
                    bit_d   = '0;
                end else if (tmr_q == TmrW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StIdle;
                    to_d    = 1'b1;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StShift: begin
                // Sample at the end of the high phase, just before clkx falls.
                if (div_q == DivW'(2 * CLK_DIV - 1)) begin
                    shreg_d = {shreg_q[DATA_WIDTH-2:0], drr_s};
                    div_d   = '0;
                    if (bit_q == BitW'(DATA_WIDTH - 1)) state_d = StDeliver;
                    else                                bit_d   = bit_q + BitW'(1);
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StDeliver: begin
                cnt_d = cnt_q + CNT_W'(1);
                tmr_d = '0;
                if (valid_q && !smp.sample_ready) begin
                    ovr_d = 1'b1;
                end else begin
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                end
                if (burst_q != '0 && cnt_d == burst_q) state_d = StIdle;
                else                                   state_d = StWaitDrdy;
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over everything except reset; stream and sticky flags are kept.
        if (state_q != StIdle && !enable) begin
            state_d = StIdle;
            data_d  = data_q;
            valid_d = valid_q && !smp.sample_ready;
            ovr_d   = ovr_q;
            to_d    = to_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tmr_q       <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            burst_q     <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            to_q        <= 1'b0;
            start_q     <= 1'b0;
            clkx_q      <= 1'b0;
            fsx_q       <= 1'b0;
            drdy_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            burst_q     <= burst_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            to_q        <= to_d;
            start_q     <= (state_d == StStart);
            clkx_q      <= (state_d == StShift) && (div_d >= DivW'(CLK_DIV));
            fsx_q       <= (state_d == StShift) && (bit_d == '0);
            drdy_prev_q <= drdy_s;
        end
    end

    assign start            = start_q;
    assign clkx             = clkx_q;
    assign fsx              = fsx_q;
    assign smp.sample_data  = data_q;
    assign smp.sample_valid = valid_q;
    assign busy             = (state_q != StIdle);
    assign overrun          = ovr_q;
    assign timeout          = to_q;

endmodule

// File: tb/tb_ads1672_capture_ctrl.sv
// Directed bench for ads1672_capture_ctrl with a behavioural ADC that
// answers each drdy_n pulse with one MSB-first word on drr.
module tb_ads1672_capture_ctrl;
    import ads1672_pkg::*;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned START_CYC = 8;
    localparam int unsigned TMO_CYC   = 100;
    localparam int unsigned LATENCY   = (2 * 24 - 1) * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] burst_len = '0;
    logic        start, clkx, fsx, busy, overrun, timeout;
    logic        drdy_n = 1'b1;
    logic        drr = 1'b1;

    ads1672_capture_ctrl_if #(.DATA_WIDTH(24)) smp ();

    ads1672_capture_ctrl #(
        .DATA_WIDTH     (24),
        .CLK_DIV        (CLK_DIV),
        .START_CYCLES   (START_CYC),
        .TIMEOUT_CYCLES (TMO_CYC),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .burst_len (burst_len),
        .start     (start),
        .drdy_n    (drdy_n),
        .clkx      (clkx),
        .fsx       (fsx),
        .drr       (drr),
        .smp       (smp),
        .busy      (busy),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ADC model: new bit on every clkx rise, frame restarts while fsx is high.
    sample_t model_word = '0;
    int      bitk = 0;
    always @(posedge clkx) begin
        if (fsx) bitk = 0;
        drr = model_word[23 - bitk];
        if (bitk < 23) bitk++;
    end

    // Monitor samples 1 ns before each rising edge, where a beat is decided.
    int      cyc = 0, clkx_rises = 0, fsx_rise_hi = 0, fsx_hi = 0, start_hi = 0;
    int      valid_rises = 0, beats = 0;
    int      last_rise_cyc = 0, valid_rise_cyc = 0, start_fall_cyc = 0, to_rise_cyc = 0;
    logic    clkx_p = 0, valid_p = 0, start_p = 0, to_p = 0;
    sample_t beat_log[$];
    initial forever begin
        @(negedge clk);
        #4;
        cyc++;
        if (clkx && !clkx_p) begin
            clkx_rises++;
            last_rise_cyc = cyc;
            if (fsx) fsx_rise_hi++;
        end
        if (fsx) fsx_hi++;
        if (start) start_hi++;
        if (smp.sample_valid && !valid_p) begin
            valid_rises++;
            valid_rise_cyc = cyc;
        end
        if (smp.sample_valid && smp.sample_ready) begin
            beats++;
            beat_log.push_back(smp.sample_data);
        end
        if (start_p && !start) start_fall_cyc = cyc;
        if (timeout && !to_p) to_rise_cyc = cyc;
        clkx_p  = clkx;
        valid_p = smp.sample_valid;
        start_p = start;
        to_p    = timeout;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic adc_convert(input sample_t w);
        model_word = w;
        tick();
        drdy_n = 1'b0;
        repeat (4) tick();
        drdy_n = 1'b1;
    endtask

    task automatic wait_start_pulse(input string name);
        for (int i = 0; i < 20 && !start; i++) tick();
        for (int i = 0; i < 40 && start; i++) tick();
        n_cmp++;
        if (start !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s start pulse: start=%b busy=%b, need start=0 busy=1", name, start, busy);
        end
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 400 && smp.sample_valid !== 1'b1; i++) tick();
        n_cmp++;
        if (smp.sample_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s wait valid: valid=%b, need 1", name, smp.sample_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({start, clkx, fsx, smp.sample_valid, busy, overrun, timeout} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b need 0000000",
                     {start, clkx, fsx, smp.sample_valid, busy, overrun, timeout});
        end
        n_cmp++;
        if (smp.sample_data !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h need 000000", smp.sample_data);
        end
        rst = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b need 0", busy);
        end
    endtask

    task automatic test_single();
        int s0, r0, f0, fr0, v0, b0, t_rise;
        s0 = start_hi; r0 = clkx_rises; f0 = fsx_hi; fr0 = fsx_rise_hi;
        v0 = valid_rises; b0 = beats;
        smp.sample_ready = 1'b0;
        burst_len = 16'd1;
        enable = 1'b1;
        wait_start_pulse("single");
        tick();
        n_cmp++;
        if (start_hi - s0 != 8) begin
            n_bad++;
            $display("FAIL single_start_width: got %0d clks need 8", start_hi - s0);
        end
        repeat (5) tick();
        adc_convert(24'hCACF0C);
        for (int i = 0; i < 50 && clkx_rises == r0; i++) tick();
        t_rise = last_rise_cyc;
        wait_valid("single");
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_busy_after_deliver: busy=%b need 0", busy);
        end
        enable = 1'b0;
        n_cmp++;
        if (smp.sample_data !== 24'hCACF0C) begin
            n_bad++;
            $display("FAIL single_data: got %h need cacf0c", smp.sample_data);
        end
        repeat (5) tick();
        n_cmp++;
        if (valid_rise_cyc - t_rise != int'(LATENCY)) begin
            n_bad++;
            $display("FAIL single_latency: got %0d need %0d", valid_rise_cyc - t_rise, LATENCY);
        end
        n_cmp++;
        if (clkx_rises - r0 != 24 || fsx_hi - f0 != 8 || fsx_rise_hi - fr0 != 1) begin
            n_bad++;
            $display("FAIL single_framing: rises=%0d fsx_clks=%0d fsx_rises=%0d need 24/8/1",
                     clkx_rises - r0, fsx_hi - f0, fsx_rise_hi - fr0);
        end
        n_cmp++;
        if (smp.sample_valid !== 1'b1 || smp.sample_data !== 24'hCACF0C) begin
            n_bad++;
            $display("FAIL single_hold: valid=%b data=%h need 1/cacf0c",
                     smp.sample_valid, smp.sample_data);
        end
        smp.sample_ready = 1'b1;
        tick();
        smp.sample_ready = 1'b0;
        tick();
        n_cmp++;
        if (smp.sample_valid !== 1'b0 || beats - b0 != 1 || valid_rises - v0 != 1) begin
            n_bad++;
            $display("FAIL single_accept: valid=%b beats=%0d valid_rises=%0d need 0/1/1",
                     smp.sample_valid, beats - b0, valid_rises - v0);
        end
    endtask

    task automatic test_back_to_back();
        sample_t words[3];
        int b0;
        words[0] = 24'h000001; words[1] = 24'h800000; words[2] = 24'hFFFFFF;
        b0 = beats;
        smp.sample_ready = 1'b1;
        burst_len = 16'd3;
        enable = 1'b1;
        wait_start_pulse("burst3");
        for (int w = 0; w < 3; w++) begin
            repeat (10) tick();
            adc_convert(words[w]);
            wait_valid("burst3");
            n_cmp++;
            if (busy !== (w < 2)) begin
                n_bad++;
                $display("FAIL burst3_busy word %0d: busy=%b need %b", w, busy, w < 2);
            end
        end
        enable = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (beats - b0 != 3) begin
            n_bad++;
            $display("FAIL burst3_count: got %0d beats need 3", beats - b0);
        end
        for (int w = 0; w < 3; w++) begin
            n_cmp++;
            if (beat_log[b0 + w] !== words[w]) begin
                n_bad++;
                $display("FAIL burst3_word %0d: got %h need %h", w, beat_log[b0 + w], words[w]);
            end
        end
        smp.sample_ready = 1'b0;
    endtask

    task automatic test_overrun();
        smp.sample_ready = 1'b0;
        burst_len = 16'd0;
        enable = 1'b1;
        wait_start_pulse("overrun");
        repeat (5) tick();
        adc_convert(24'h123456);
        wait_valid("overrun");
        n_cmp++;
        if (smp.sample_data !== 24'h123456 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_first: data=%h ovr=%b need 123456/0", smp.sample_data, overrun);
        end
        repeat (10) tick();
        adc_convert(24'hABCDEF);
        for (int i = 0; i < 400 && overrun !== 1'b1; i++) tick();
        n_cmp++;
        if (overrun !== 1'b1 || smp.sample_data !== 24'h123456 || smp.sample_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_drop: ovr=%b data=%h valid=%b need 1/123456/1",
                     overrun, smp.sample_data, smp.sample_valid);
        end
        enable = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || smp.sample_valid !== 1'b1 || overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_abort_keep: busy=%b valid=%b ovr=%b need 0/1/1",
                     busy, smp.sample_valid, overrun);
        end
        smp.sample_ready = 1'b1;
        tick();
        smp.sample_ready = 1'b0;
        tick();
        n_cmp++;
        if (smp.sample_valid !== 1'b0 || beat_log[beat_log.size() - 1] !== 24'h123456) begin
            n_bad++;
            $display("FAIL overrun_accept: valid=%b last=%h need 0/123456",
                     smp.sample_valid, beat_log[beat_log.size() - 1]);
        end
    endtask

    task automatic test_timeout();
        int r0;
        r0 = clkx_rises;
        burst_len = 16'd0;
        enable = 1'b1;
        for (int i = 0; i < 20 && !start; i++) tick();
        n_cmp++;
        if (overrun !== 1'b0 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_clear_on_start: ovr=%b tmo=%b need 0/0", overrun, timeout);
        end
        for (int i = 0; i < 300 && timeout !== 1'b1; i++) tick();
        n_cmp++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_flag: tmo=%b busy=%b need 1/0", timeout, busy);
        end
        enable = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (to_rise_cyc - start_fall_cyc != int'(TMO_CYC) || clkx_rises != r0) begin
            n_bad++;
            $display("FAIL timeout_window: got %0d clks, %0d clkx rises; need %0d, 0",
                     to_rise_cyc - start_fall_cyc, clkx_rises - r0, TMO_CYC);
        end
    endtask

    task automatic test_abort();
        int n_rise, b0, s0;
        logic prev;
        b0 = beats;
        smp.sample_ready = 1'b0;
        burst_len = 16'd0;
        enable = 1'b1;
        wait_start_pulse("abort");
        repeat (5) tick();
        adc_convert(24'h5A5A5A);
        n_rise = 0;
        prev = clkx;
        for (int i = 0; i < 300 && n_rise < 11; i++) begin
            tick();
            if (clkx && !prev) n_rise++;
            prev = clkx;
        end
        enable = 1'b0;
        tick();
        n_cmp++;
        if (clkx !== 1'b0 || fsx !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_outputs: clkx=%b fsx=%b busy=%b need 0/0/0", clkx, fsx, busy);
        end
        repeat (250) tick();
        n_cmp++;
        if (smp.sample_valid !== 1'b0 || beats != b0) begin
            n_bad++;
            $display("FAIL abort_no_word: valid=%b beats=%0d need 0/0", smp.sample_valid, beats - b0);
        end
        s0 = start_hi;
        enable = 1'b1;
        wait_start_pulse("restart");
        enable = 1'b0;
        tick();
        n_cmp++;
        if (start_hi - s0 != 8 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_restart: start clks=%0d busy=%b need 8/0", start_hi - s0, busy);
        end
    endtask

    task automatic test_reset_mid_shift();
        int n_rise;
        logic prev;
        smp.sample_ready = 1'b0;
        burst_len = 16'd0;
        enable = 1'b1;
        wait_start_pulse("rst_mid");
        repeat (5) tick();
        adc_convert(24'h0F0F0F);
        wait_valid("rst_mid");
        repeat (10) tick();
        adc_convert(24'hF0F0F0);
        n_rise = 0;
        prev = clkx;
        for (int i = 0; i < 300 && n_rise < 5; i++) begin
            tick();
            if (clkx && !prev) n_rise++;
            prev = clkx;
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({start, clkx, fsx, smp.sample_valid, busy, overrun, timeout} !== 7'b0
            || smp.sample_data !== 24'h0) begin
            n_bad++;
            $display("FAIL rst_mid_shift: flags=%b data=%h need 0000000/000000",
                     {start, clkx, fsx, smp.sample_valid, busy, overrun, timeout},
                     smp.sample_data);
        end
        enable = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        smp.sample_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_abort();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
